// File: rtl/mmc3_a12_filter.sv
// rtl/mmc3_a12_filter.sv - MMC3 A12 synchronizer, deglitcher and low-time qualifier
module mmc3_a12_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DG_LEN      = 2,
    parameter int MIN_LOW_M2  = 2,
    parameter int M2_TO_CLKS  = 200
) (
    input  logic       clk,
    input  logic       map_rst_n,
    input  logic       ppu_a12,
    input  logic       m2,
    input  logic       ss_act,
    output logic       a12d,
    output logic       a12_rise,
    output logic       a12_stb,
    output logic [2:0] low_m2_cnt
);

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_ARMED = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    localparam logic [2:0] LP_MIN_M2  = 3'(MIN_LOW_M2);
    localparam logic [7:0] LP_TO_CLKS = 8'(M2_TO_CLKS);
    localparam logic [2:0] LP_M2_SAT  = 3'd7;
    localparam logic [7:0] LP_CLK_SAT = 8'd255;

    logic [SYNC_STAGES-1:0] r_a12_sync;
    logic [SYNC_STAGES-1:0] r_m2_sync;
    logic                   r_m2_prev;
    logic [DG_LEN-1:0]      r_taps;
    logic                   r_a12d;
    logic                   r_rise;
    state_t                 r_state;
    logic [2:0]             r_low_m2;
    logic [7:0]             r_low_clk;

    logic w_a12_s;
    logic w_m2_s;
    logic w_m2_fall;
    logic w_all_hi;
    logic w_all_lo;
    logic w_rise;
    logic w_fall;
    logic w_qual;
    logic w_count_en;

    assign w_a12_s   = r_a12_sync[SYNC_STAGES-1];
    assign w_m2_s    = r_m2_sync[SYNC_STAGES-1];
    assign w_m2_fall = r_m2_prev & ~w_m2_s;

    // Bring both asynchronous inputs into the clk domain and keep the previous M2 sample for edge detection
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            r_a12_sync <= '0;
            r_m2_sync  <= '0;
            r_m2_prev  <= 1'b0;
        end else begin
            r_a12_sync <= {r_a12_sync[SYNC_STAGES-2:0], ppu_a12};
            r_m2_sync  <= {r_m2_sync[SYNC_STAGES-2:0], m2};
            r_m2_prev  <= w_m2_s;
        end
    end

    generate
        if (DG_LEN == 1) begin : g_tap_single
            // Single-tap filter: the synchronized sample alone decides the level
            always_ff @(posedge clk or negedge map_rst_n) begin
                if (!map_rst_n) begin
                    r_taps <= '0;
                end else begin
                    r_taps <= w_a12_s;
                end
            end
        end else begin : g_tap_shift
            // Deglitch shift register of synchronized A12 samples
            always_ff @(posedge clk or negedge map_rst_n) begin
                if (!map_rst_n) begin
                    r_taps <= '0;
                end else begin
                    r_taps <= {r_taps[DG_LEN-2:0], w_a12_s};
                end
            end
        end
    endgenerate

    assign w_all_hi = &r_taps;
    assign w_all_lo = ~|r_taps;
    assign w_rise   = ~r_a12d & w_all_hi;
    assign w_fall   = r_a12d & w_all_lo;

    // Qualification looks only at counter values registered before the current edge
    assign w_qual     = (r_low_m2 >= LP_MIN_M2) | (r_low_clk >= LP_TO_CLKS);
    assign w_count_en = ~r_a12d & ~ss_act;

    // Low-phase counters: cleared on the filtered rise, frozen while high or during save-state access
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            r_low_m2  <= '0;
            r_low_clk <= '0;
        end else if (w_rise) begin
            r_low_m2  <= '0;
            r_low_clk <= '0;
        end else if (w_count_en) begin
            if (w_m2_fall && (r_low_m2 != LP_M2_SAT)) begin
                r_low_m2 <= r_low_m2 + 3'd1;
            end
            if (r_low_clk != LP_CLK_SAT) begin
                r_low_clk <= r_low_clk + 8'd1;
            end
        end
    end

    // Filtered level, qualification state and the single-clock rise pulse
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            r_state <= S_LOW;
            r_a12d  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (w_all_hi) begin
                r_a12d <= 1'b1;
            end else if (w_all_lo) begin
                r_a12d <= 1'b0;
            end
            case (r_state)
                S_LOW: begin
                    if (w_rise) begin
                        r_state <= S_HIGH;
                    end else if (w_qual) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_rise) begin
                        r_rise  <= ~ss_act;
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        r_state <= S_LOW;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                end
            endcase
        end
    end

    assign a12d       = r_a12d;
    assign a12_rise   = r_rise;
    assign a12_stb    = w_qual & (r_state == S_ARMED);
    assign low_m2_cnt = r_low_m2;

endmodule

// File: doc/mmc3_a12_filter.md
# mmc3_a12_filter

Front end of the MMC3-family scanline IRQ path. Samples the raw asynchronous PPU A12 line and the CPU M2 line on the mapper clock, removes glitches, and qualifies each A12 rise by the A12 low time measured in M2 falling edges. It emits a single-clock `a12_rise` pulse that the IRQ counter stage consumes as its clock enable. That pulse replaces the IRQ stage's own `posedge` A12 clocking.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `ppu_a12` and `m2`; legal range 2–3.
- `DG_LEN`, 2: consecutive equal synchronized samples required to change the filtered level; legal range 1–4.
- `MIN_LOW_M2`, 2: M2 falling edges A12 must stay low before a rise is accepted; legal range 1–7.
- `M2_TO_CLKS`, 200: low-time fallback in clk cycles, used when M2 is stalled; legal range 1–255.

Ports:
- `clk`  in  1  mapper clock; all state changes on its rising edge.
- `map_rst_n`  in  1  asynchronous, active-low reset.
- `ppu_a12`  in  1  raw PPU address bit 12; asynchronous to `clk`.
- `m2`  in  1  raw CPU M2; asynchronous to `clk`.
- `ss_act`  in  1  save-state access active; freezes qualification.
- `a12d`  out  1  filtered A12 level.
- `a12_rise`  out  1  one-clk pulse on each qualified rise of `a12d`.
- `a12_stb`  out  1  level; high while the current low phase already qualifies.
- `low_m2_cnt`  out  3  M2 falling edges counted in the current low phase; saturates at 7.

## Operation
- Synchronizers: `ppu_a12` and `m2` each pass through `SYNC_STAGES` flops, giving `a12_s` and `m2_s`.
- M2 edge: `m2_fall` = previous `m2_s` high and current `m2_s` low. It is a one-clk internal pulse.
- Glitch filter:
  - A `DG_LEN`-deep shift register holds samples of `a12_s`.
  - When all taps are 1, `a12d` is set to 1. When all taps are 0, `a12d` is set to 0. Otherwise `a12d` holds.
- Low-time counters (update only while `a12d`=0 and `ss_act`=0):
  - `low_m2_cnt` increments on each `m2_fall` and saturates at 7.
  - `low_clk`, 8 bits, increments every clk and saturates at 255.
  - Both counters clear on the clock in which `a12d` becomes 1.
  - With `ss_act`=1, both counters hold.
- Qualification: `qual` = `low_m2_cnt` >= `MIN_LOW_M2` OR `low_clk` >= `M2_TO_CLKS`. `a12_stb` = `qual` AND state S_ARMED.
- State machine:
  - S_LOW: `a12d`=0, not yet qualified. Go to S_ARMED when `qual` becomes 1. Go to S_HIGH on a filtered rise, with no pulse.
  - S_ARMED: qualified low. On a filtered rise, assert `a12_rise` in the same clock that `a12d` goes to 1, then go to S_HIGH. If `ss_act`=1, suppress the pulse but still go to S_HIGH.
  - S_HIGH: `a12d`=1. Go to S_LOW on a filtered fall; counters restart from 0.
- Simultaneous events: an `m2_fall` in the same clock as the filtered rise is not counted. Qualification uses the counter values registered before that edge.
- A pulse is never generated by a falling edge or while the filter is indeterminate.

## Timing
- Reset (async assert, synchronous use after release):
  - `a12d`=0, `a12_rise`=0, `a12_stb`=0, `low_m2_cnt`=0.
  - `low_clk`=0, state S_LOW, synchronizers and filter taps all 0.
- Reset asserted mid-operation: all outputs go to their reset values immediately, with no clock needed. A rise that was in flight is discarded.
- Latency: `ppu_a12` held high from the sampling edge E produces `a12d`=1 and `a12_rise` at edge E+`SYNC_STAGES`+`DG_LEN`. With default parameters this is E+4.
- `a12_rise` is exactly one clk wide. Consecutive pulses are at least `DG_LEN`+1 clocks apart, because a filtered fall must occur between them.
- A `ppu_a12` pulse shorter than `DG_LEN` clocks is never visible on `a12d`.
- `low_m2_cnt` reflects each `m2_fall` `SYNC_STAGES`+1 clocks after the falling edge of `m2`.
- Saturation: `low_m2_cnt` stays at 7 and `low_clk` stays at 255; neither wraps.

## Test plan
- Reset: pulse `map_rst_n` low mid-count → all outputs read 0 during reset. The first rise after reset with no M2 edges and `low_clk`<200 gives no `a12_rise`.
- Normal scanline:
  - Stimulus: A12 low for 3 M2 falls, then high for 8 clks.
  - Required: `low_m2_cnt` reaches 3 and `a12_stb` goes high. Exactly one `a12_rise` occurs, 4 clks after A12 is first sampled high. `low_m2_cnt` then returns to 0.
- Short low (sprite fetch):
  - Stimulus: A12 low for 1 M2 fall, then high.
  - Required: no `a12_rise`, state reaches S_HIGH, and the next qualified low gives a pulse.
- Glitch: a 1-clk low spike, or a 1-clk high spike, on `ppu_a12` → `a12d` unchanged, no pulse, counters unaffected.
- M2 stall: M2 held high, A12 low for 200 clks, then high → `a12_stb` high at clk 200 and one `a12_rise`.
- Save state: `ss_act`=1 across a qualified rise → no pulse, `a12d` still rises, and `low_m2_cnt` is frozen during the preceding low phase.
